// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - fetch-side and execute-side handshake bundle for imm_decode_stage
interface imm_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_shamt;
  logic [4:0]      out_aluop;
  logic [16:0]     out_imm17;
  logic [26:0]     out_target;
  logic [1:0]      out_fmt;
  logic            out_illegal;
  logic [PC_W-1:0] out_pc;

  modport slave (
    input  flush, in_valid, in_insn, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt, out_shamt,
           out_aluop, out_imm17, out_target, out_fmt, out_illegal, out_pc
  );

  modport master (
    output flush, in_valid, in_insn, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt, out_shamt,
           out_aluop, out_imm17, out_target, out_fmt, out_illegal, out_pc
  );
endinterface

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - decode stage with registered output and one-entry skid buffer
module imm_decode_stage #(
  parameter int PC_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  imm_decode_stage_if.slave    io
);
  logic            m_valid;
  logic [31:0]     m_insn;
  logic [PC_W-1:0] m_pc;
  logic [1:0]      m_fmt;
  logic            m_illegal;
  logic            s_valid;
  logic [31:0]     s_insn;
  logic [PC_W-1:0] s_pc;

  // {illegal, fmt}; unknown opcodes still flow, tagged illegal with fmt R
  function automatic logic [2:0] decode(input logic [4:0] op);
    logic [2:0] r;
    r = 3'b100;
    case (op)
      5'b00000: r = 3'b000;
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: r = 3'b001;
      5'b00001, 5'b00011, 5'b10110, 5'b10101: r = 3'b010;
      5'b00100: r = 3'b011;
      default: r = 3'b100;
    endcase
    return r;
  endfunction

  logic [2:0] in_dec;
  logic [2:0] s_dec;
  logic       accept;

  assign in_dec = decode(io.in_insn[31:27]);
  assign s_dec  = decode(s_insn[31:27]);
  assign accept = io.in_valid & ~s_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid   <= 1'b0;
      m_insn    <= '0;
      m_pc      <= '0;
      m_fmt     <= '0;
      m_illegal <= 1'b0;
      s_valid   <= 1'b0;
      s_insn    <= '0;
      s_pc      <= '0;
    end else if (io.flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      // skid full implies M full; fetch is blocked until S drains into M
      if (io.out_ready) begin
        m_insn    <= s_insn;
        m_pc      <= s_pc;
        m_fmt     <= s_dec[1:0];
        m_illegal <= s_dec[2];
        s_valid   <= 1'b0;
      end
    end else if (accept) begin
      if (!m_valid || io.out_ready) begin
        m_valid   <= 1'b1;
        m_insn    <= io.in_insn;
        m_pc      <= io.in_pc;
        m_fmt     <= in_dec[1:0];
        m_illegal <= in_dec[2];
      end else begin
        s_valid <= 1'b1;
        s_insn  <= io.in_insn;
        s_pc    <= io.in_pc;
      end
    end else if (io.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // in_ready comes straight from a flop, so out_ready never reaches fetch combinationally
  assign io.in_ready    = ~s_valid;
  assign io.out_valid   = m_valid;
  assign io.out_opcode  = m_insn[31:27];
  assign io.out_rd      = m_insn[26:22];
  assign io.out_rs      = m_insn[21:17];
  assign io.out_rt      = m_insn[16:12];
  assign io.out_shamt   = m_insn[11:7];
  assign io.out_aluop   = m_insn[6:2];
  assign io.out_imm17   = m_insn[16:0];
  assign io.out_target  = m_insn[26:0];
  assign io.out_fmt     = m_fmt;
  assign io.out_illegal = m_illegal;
  assign io.out_pc      = m_pc;
endmodule
